register_bank_sb: RTL and testbench
===================================

Name: register_bank_sb

Overview:
- Parametrised successor to the 8x16 register bank.
- Adds generic width and depth, and an optional write-to-read bypass.
- Adds an optional hardwired-zero register 0 and a per-register busy scoreboard for in-flight producers.
- Adds a synchronous clear sequencer that zeroes the bank one entry per cycle without asserting reset.
- Sits between the decode/issue stage, which reads operands and locks destinations, and writeback, which writes results and releases locks.

Parameters:
- DATA_W, 16: register width in bits.
- ADDR_W, 3: address width; depth is 2**ADDR_W entries (internal localparam DEPTH).
- BYPASS, 1: 1 = a same-cycle write to a read address is forwarded to the read output; 0 = the read returns the pre-write value.
- R0_ZERO, 0: 1 = entry 0 always reads 0, writes and locks to it are ignored, and it is never busy.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- raddr1  input  ADDR_W  read port 1 address.
- raddr2  input  ADDR_W  read port 2 address.
- rdata1  output  DATA_W  registered read data, port 1.
- rdata2  output  DATA_W  registered read data, port 2.
- busy1  output  1  registered busy flag of raddr1, aligned with rdata1.
- busy2  output  1  registered busy flag of raddr2, aligned with rdata2.
- wen  input  1  write enable.
- waddr  input  ADDR_W  write address.
- wdata  input  DATA_W  write data.
- lock_en  input  1  mark lock_addr busy (producer issued).
- lock_addr  input  ADDR_W  register to lock.
- clr  input  1  start-clear request, sampled in IDLE only.
- clr_busy  output  1  high while a clear sweep is in progress.
- clr_done  output  1  one-cycle pulse on the final sweep cycle.

Behaviour:
- Reset (async, rst=1):
  - All entries become 0 and all busy bits become 0.
  - rdata1/2, busy1/2, clr_busy and clr_done go to 0; FSM goes to IDLE; the sweep index goes to 0.
  - Reset mid-sweep aborts the sweep with no clr_done.
- Reads:
  - Both ports are read every cycle with 1-cycle latency: rdataN(t+1) = entry[raddrN(t)] and busyN(t+1) = busy[raddrN(t)].
  - No read enable.
  - The same address on both ports is legal; both ports return identical values.
- Write:
  - When wen=1 in IDLE, entry[waddr] <= wdata and busy[waddr] <= 0.
  - wen=0 leaves the bank unchanged.
- Bypass with BYPASS=1 and wen=1 and raddrN==waddr in the same cycle:
  - rdataN(t+1) = wdata.
  - busyN(t+1) = 0, except when a same-cycle lock targets the same address (see Lock).
- Bypass with BYPASS=0: rdataN(t+1) = old entry value and busyN(t+1) = old busy value.
- Lock:
  - lock_en=1 in IDLE sets busy[lock_addr] <= 1.
  - A lock and a write to the same address in the same cycle: the data write happens and busy ends at 1 (the lock wins).
  - With BYPASS=1, a same-cycle read of that address reports busy=1.
  - Relocking an already-busy entry leaves it busy.
- R0_ZERO=1:
  - Writes and locks to address 0 are dropped.
  - Reads of address 0 return 0 with busy=0, bypass included.
- Clear FSM, states IDLE and SWEEP:
  - IDLE: clr=1 moves to SWEEP with idx=0; clr_busy rises the next cycle.
  - SWEEP: each cycle sets entry[idx] <= 0, busy[idx] <= 0 and idx <= idx+1.
  - When idx==DEPTH-1, clr_done=1 for that cycle, the FSM returns to IDLE and clr_busy drops the following cycle.
  - A sweep takes exactly DEPTH cycles.
  - In SWEEP, wen and lock_en are ignored (dropped, not queued) and clr is ignored.
  - Reads continue in SWEEP and return current contents; already-cleared entries read 0.
  - Bypass is disabled in SWEEP.
  - clr together with wen or lock_en in IDLE: the write/lock that cycle is performed, then the sweep starts.
- Widths: no arithmetic; all address compares are on the full ADDR_W bits; idx is ADDR_W bits and wraps only at the FSM exit.

Test Plan:
1. Reset, then read addresses 0..7 -> all rdata=0, busy=0; after rst is deasserted, the next cycle still shows 0.
2. Write 0xBEEF to addr 3, then read addr 3 on both ports the next cycle -> rdata1=rdata2=0xBEEF one cycle after the read address is presented.
3. Bypass check: write 0x1234 to addr 5 while raddr1=5 with BYPASS=1 -> rdata1=0x1234 next cycle. Repeat with BYPASS=0 -> rdata1 shows the prior value, then 0x1234 on a second read.
4. Scoreboard check:
   - lock addr 2, then read -> busy1=1.
   - Write 0x00AA to addr 2 -> busy=0 and rdata=0x00AA.
   - Simultaneous lock and write to addr 6 with raddr2=6 -> busy2=1 and rdata2=wdata.
5. Clear sweep (DEPTH=8):
   - Fill all entries with nonzero values, lock addr 4, pulse clr -> clr_busy high for 8 cycles and clr_done on the 8th.
   - A wen issued mid-sweep is dropped.
   - Afterwards all entries read 0 and addr 4 reads busy=0.
6. Reset mid-sweep: assert rst on sweep cycle 3 -> clr_busy=0, no clr_done, all entries 0. With R0_ZERO=1, writing 0xFFFF to addr 0 then reading it -> 0, busy=0.

Source files
------------

// File: rtl/register_bank_sb.sv
// Parametrised register bank with read bypass, optional zero register, busy scoreboard
// and a one-entry-per-cycle synchronous clear sweep.
module register_bank_sb #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 3,
  parameter bit          BYPASS  = 1'b1,
  parameter bit          R0_ZERO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              busy1,
  output logic              busy2,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              lock_en,
  input  logic [ADDR_W-1:0] lock_addr,
  input  logic              clr,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;

  logic [ADDR_W-1:0] raddr [2];
  logic [DATA_W-1:0] rd_q [2];
  logic [DATA_W-1:0] rd_d [2];
  logic [1:0]        bs_q, bs_d;

  logic idle, last, wr_ok, lk_ok;

  assign idle  = (state_q == StIdle);
  assign last  = (idx_q == ADDR_W'(DEPTH - 1));
  // Writes and locks only land in IDLE; entry 0 is immutable when hardwired to zero.
  assign wr_ok = wen && idle && !(R0_ZERO && (waddr == '0));
  assign lk_ok = lock_en && idle && !(R0_ZERO && (lock_addr == '0));

  assign clr_busy = (state_q == StSweep);
  assign clr_done = (state_q == StSweep) && last;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (clr) begin
          state_d = StSweep;
          idx_d   = '0;
        end
      end
      StSweep: begin
        if (last) begin
          state_d = StIdle;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Lock is applied after the write so a same-cycle lock leaves the entry busy.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (wr_ok) begin
      mem_d[waddr]  = wdata;
      busy_d[waddr] = 1'b0;
    end
    if (lk_ok) begin
      busy_d[lock_addr] = 1'b1;
    end
    if (!idle) begin
      mem_d[idx_q]  = '0;
      busy_d[idx_q] = 1'b0;
    end
  end

  assign raddr[0] = raddr1;
  assign raddr[1] = raddr2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_d[p] = mem_q[raddr[p]];
      bs_d[p] = busy_q[raddr[p]];
      if (BYPASS && wr_ok && (waddr == raddr[p])) begin
        rd_d[p] = wdata;
        bs_d[p] = lk_ok && (lock_addr == raddr[p]);
      end
      if (R0_ZERO && (raddr[p] == '0)) begin
        rd_d[p] = '0;
        bs_d[p] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      busy_q  <= '0;
      bs_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_q[0] <= '0;
      rd_q[1] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      bs_q    <= bs_d;
      mem_q   <= mem_d;
      rd_q[0] <= rd_d[0];
      rd_q[1] <= rd_d[1];
    end
  end

  assign rdata1 = rd_q[0];
  assign rdata2 = rd_q[1];
  assign busy1  = bs_q[0];
  assign busy2  = bs_q[1];

endmodule

// File: tb/tb_register_bank_sb.sv
// Scoreboard bench: two instances (bypass/no-zero-reg and no-bypass/zero-reg) share stimulus
// and are compared each cycle against a behavioural model of the bank.
module tb_register_bank_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  raddr1, raddr2, waddr, lock_addr;
  logic [15:0] wdata;
  logic        wen, lock_en, clr;

  logic [15:0] a_rd1, a_rd2, b_rd1, b_rd2;
  logic        a_b1, a_b2, b_b1, b_b2, a_cb, a_cd, b_cb, b_cd;

  always #5 clk = ~clk;

  register_bank_sb #(.DATA_W(16), .ADDR_W(3), .BYPASS(1'b1), .R0_ZERO(1'b0)) dut_a (
    .clk(clk), .rst(rst), .raddr1(raddr1), .raddr2(raddr2), .rdata1(a_rd1), .rdata2(a_rd2),
    .busy1(a_b1), .busy2(a_b2), .wen(wen), .waddr(waddr), .wdata(wdata), .lock_en(lock_en),
    .lock_addr(lock_addr), .clr(clr), .clr_busy(a_cb), .clr_done(a_cd)
  );

  register_bank_sb #(.DATA_W(16), .ADDR_W(3), .BYPASS(1'b0), .R0_ZERO(1'b1)) dut_b (
    .clk(clk), .rst(rst), .raddr1(raddr1), .raddr2(raddr2), .rdata1(b_rd1), .rdata2(b_rd2),
    .busy1(b_b1), .busy2(b_b2), .wen(wen), .waddr(waddr), .wdata(wdata), .lock_en(lock_en),
    .lock_addr(lock_addr), .clr(clr), .clr_busy(b_cb), .clr_done(b_cd)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] a_rd1, a_rd2, b_rd1, b_rd2;
    logic        a_b1, a_b2, b_b1, b_b2, cb, cd;
  } exp_t;

  exp_t sb[$];

  logic [15:0] m_mem  [2][8];
  logic        m_busy [2][8];
  logic        m_sweep;
  logic [2:0]  m_idx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // k=0: bypass on, no zero register; k=1: bypass off, hardwired zero register.
  function automatic logic [16:0] mread(input int k, input logic [2:0] ra);
    logic byp = (k == 0);
    logic z   = (k == 1);
    logic wr  = wen && !m_sweep && !(z && waddr == 3'd0);
    logic lk  = lock_en && !m_sweep && !(z && lock_addr == 3'd0);
    if (z && ra == 3'd0) return 17'd0;
    if (byp && wr && waddr == ra) return {lk && (lock_addr == ra), wdata};
    return {m_busy[k][ra], m_mem[k][ra]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 8; i++) begin
        m_mem[k][i]  = 16'd0;
        m_busy[k][i] = 1'b0;
      end
    m_sweep = 1'b0;
    m_idx   = 3'd0;
    sb.delete();
  endtask

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      logic z  = (k == 1);
      logic wr = wen && !m_sweep && !(z && waddr == 3'd0);
      logic lk = lock_en && !m_sweep && !(z && lock_addr == 3'd0);
      if (wr) begin
        m_mem[k][waddr]  = wdata;
        m_busy[k][waddr] = 1'b0;
      end
      if (lk) m_busy[k][lock_addr] = 1'b1;
      if (m_sweep) begin
        m_mem[k][m_idx]  = 16'd0;
        m_busy[k][m_idx] = 1'b0;
      end
    end
    if (m_sweep) begin
      if (m_idx == 3'd7) begin
        m_sweep = 1'b0;
        m_idx   = 3'd0;
      end else begin
        m_idx = m_idx + 3'd1;
      end
    end else if (clr) begin
      m_sweep = 1'b1;
      m_idx   = 3'd0;
    end
  endtask

  task automatic step();
    exp_t        e;
    logic [16:0] r;
    r = mread(0, raddr1); e.a_rd1 = r[15:0]; e.a_b1 = r[16];
    r = mread(0, raddr2); e.a_rd2 = r[15:0]; e.a_b2 = r[16];
    r = mread(1, raddr1); e.b_rd1 = r[15:0]; e.b_b1 = r[16];
    r = mread(1, raddr2); e.b_rd2 = r[15:0]; e.b_b2 = r[16];
    model_update();
    e.cb = m_sweep;
    e.cd = m_sweep && (m_idx == 3'd7);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("a_rdata1", a_rd1, e.a_rd1);
    chk("a_rdata2", a_rd2, e.a_rd2);
    chk("a_busy1", a_b1, e.a_b1);
    chk("a_busy2", a_b2, e.a_b2);
    chk("b_rdata1", b_rd1, e.b_rd1);
    chk("b_rdata2", b_rd2, e.b_rd2);
    chk("b_busy1", b_b1, e.b_b1);
    chk("b_busy2", b_b2, e.b_b2);
    chk("a_clr_busy", a_cb, e.cb);
    chk("b_clr_busy", b_cb, e.cb);
    chk("a_clr_done", a_cd, e.cd);
    chk("b_clr_done", b_cd, e.cd);
  endtask

  task automatic quiet();
    wen = 1'b0; lock_en = 1'b0; clr = 1'b0;
  endtask

  initial begin
    int cnt;
    int done_at;
    rst = 1'b1;
    raddr1 = 3'd0; raddr2 = 3'd0; waddr = 3'd0; lock_addr = 3'd0; wdata = 16'd0;
    quiet();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata1", a_rd1, 16'd0);
    chk("rst_busy1", a_b1, 1'b0);
    chk("rst_clr_busy", a_cb, 1'b0);
    chk("rst_clr_done", a_cd, 1'b0);
    rst = 1'b0;

    for (int a = 0; a < 8; a++) begin
      raddr1 = 3'(a); raddr2 = 3'(7 - a);
      step();
    end

    // Write then read on both ports.
    wen = 1'b1; waddr = 3'd3; wdata = 16'hBEEF; step();
    wen = 1'b0; raddr1 = 3'd3; raddr2 = 3'd3; step();
    chk("beef_p1", a_rd1, 16'hBEEF);
    chk("beef_p2", a_rd2, 16'hBEEF);

    // Same-cycle write/read: forwarded on dut_a, old value on dut_b.
    wen = 1'b1; waddr = 3'd5; wdata = 16'h5555; step();
    wdata = 16'h1234; raddr1 = 3'd5; step();
    chk("bypass_on", a_rd1, 16'h1234);
    chk("bypass_off", b_rd1, 16'h5555);
    wen = 1'b0; step();
    chk("bypass_off_2nd", b_rd1, 16'h1234);

    // Scoreboard.
    lock_en = 1'b1; lock_addr = 3'd2; step();
    lock_en = 1'b0; raddr1 = 3'd2; step();
    chk("lock_busy", a_b1, 1'b1);
    wen = 1'b1; waddr = 3'd2; wdata = 16'h00AA; step();
    wen = 1'b0; step();
    chk("wr_release", a_b1, 1'b0);
    chk("wr_data", a_rd1, 16'h00AA);
    wen = 1'b1; lock_en = 1'b1; waddr = 3'd6; lock_addr = 3'd6; wdata = 16'h6666; raddr2 = 3'd6;
    step();
    chk("lockwr_busy2", a_b2, 1'b1);
    chk("lockwr_rdata2", a_rd2, 16'h6666);
    wen = 1'b0; step();
    lock_en = 1'b0; step();
    chk("relock_busy", a_b2, 1'b1);

    for (int n = 0; n < 40; n++) begin
      wen = 1'($urandom_range(0, 1)); lock_en = ($urandom_range(0, 3) == 0);
      waddr = 3'($urandom_range(0, 7)); lock_addr = 3'($urandom_range(0, 7));
      raddr1 = 3'($urandom_range(0, 7)); raddr2 = 3'($urandom_range(0, 7));
      wdata = 16'($urandom);
      step();
    end
    quiet();

    // Clear sweep over a full bank with a locked entry and a mid-sweep write.
    for (int i = 0; i < 8; i++) begin
      wen = 1'b1; waddr = 3'(i); wdata = 16'hA001 + 16'(i); step();
    end
    wen = 1'b0; lock_en = 1'b1; lock_addr = 3'd4; step();
    lock_en = 1'b0;
    clr = 1'b1; wen = 1'b1; waddr = 3'd7; wdata = 16'h7777; step();
    quiet();
    cnt = 0; done_at = 0;
    for (int c = 1; c <= 12; c++) begin
      if (a_cb) cnt++;
      if (a_cd) done_at = c;
      raddr1 = 3'(c); raddr2 = 3'(c + 3);
      if (c == 3) begin
        wen = 1'b1; waddr = 3'd1; wdata = 16'hFFFF; lock_en = 1'b1; lock_addr = 3'd1; clr = 1'b1;
      end else begin
        quiet();
      end
      step();
    end
    quiet();
    chk("sweep_len", cnt, 8);
    chk("sweep_done_at", done_at, 8);
    for (int a = 0; a < 8; a++) begin
      raddr1 = 3'(a); raddr2 = 3'(a); step();
      chk("swept_rdata", a_rd1, 16'd0);
      if (a == 4) chk("swept_busy4", a_b1, 1'b0);
    end

    // Reset on sweep cycle 3.
    wen = 1'b1; waddr = 3'd2; wdata = 16'h2222; step();
    waddr = 3'd5; wdata = 16'h5A5A; step();
    wen = 1'b0; clr = 1'b1; raddr1 = 3'd5; step();
    clr = 1'b0; step(); step();
    chk("pre_rst_clr_busy", a_cb, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_clr_busy", a_cb, 1'b0);
    chk("midrst_clr_done", a_cd, 1'b0);
    chk("midrst_rdata1", a_rd1, 16'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int a = 0; a < 8; a++) begin
      raddr1 = 3'(a); raddr2 = 3'(7 - a); step();
    end

    // Hardwired zero register on dut_b.
    wen = 1'b1; lock_en = 1'b1; waddr = 3'd0; lock_addr = 3'd0; wdata = 16'hFFFF; raddr1 = 3'd0;
    step();
    chk("r0_same_cycle", b_rd1, 16'd0);
    quiet(); step();
    chk("r0_rdata", b_rd1, 16'd0);
    chk("r0_busy", b_b1, 1'b0);
    chk("no_r0_rdata", a_rd1, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
